// File: rtl/kgp_risc_pkg.sv
// Shared encodings for the multicycle KGP_RISC datapath: FSM states, control-field
// values driven back by the control unit, and instruction field positions.
package kgp_risc_pkg;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_COMP, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS
  } alu_op_e;

  typedef enum logic [1:0] {SRC_RT, SRC_IMM, SRC_SHAMT, SRC_RT_SHIFT} alu_src_e;

  typedef enum logic [1:0] {DEST_RS, DEST_RT, DEST_LINK} reg_dest_e;

  typedef enum logic [1:0] {M2R_ALU, M2R_MEM, M2R_LINK} mem_to_reg_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_JUMP, BR_JR, BR_NEG, BR_ZERO, BR_NZERO, BR_CARRY, BR_NCARRY
  } branch_e;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int SHAMT_LSB  = 11;
  localparam int IMM_LSB    = 0;
  localparam int PDA_LSB    = 0;
  localparam int FUNC_LSB   = 0;
  localparam int REG_IDX_W  = 5;

  localparam logic [REG_IDX_W-1:0] LINK_REG = 5'd31;

endpackage

// File: rtl/mc_register_file.sv
// NREGS x DATA_W register file: two combinational reads, one synchronous write.
// Indices at or above NREGS read as zero and drop writes.
module mc_register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (32'(wr_addr) < NREGS)) begin
      regs[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data_a = (32'(rd_addr_a) < NREGS) ? regs[rd_addr_a[IDX_W-1:0]] : '0;
  assign rd_data_b = (32'(rd_addr_b) < NREGS) ? regs[rd_addr_b[IDX_W-1:0]] : '0;

endmodule

// File: rtl/multicycle_data_path.sv
// Multicycle KGP_RISC datapath: FETCH/EXEC/[MEM]/WB, 3 cycles per instruction, 4+ with memory.
// Stalls in FETCH until instr_valid and in MEM until mem_ack; request outputs held stable meanwhile.
module multicycle_data_path
  import kgp_risc_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       NREGS    = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  output logic              instr_ready,
  output logic [DATA_W-1:0] pc,
  output logic [5:0]        opcode,
  output logic [5:0]        funccode,
  input  logic [1:0]        reg_dest,
  input  logic              reg_write,
  input  logic              mem_write,
  input  logic [2:0]        ALUop,
  input  logic [1:0]        ALUsource,
  input  logic [1:0]        mem_to_reg,
  input  logic [2:0]        branch,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] result,
  output logic              retire
);

  localparam int SH_W = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] pc_q, result_q, target_q, load_q;
  logic              carry_q, taken_q;

  logic [4:0]        rs_idx, rt_idx, wr_idx;
  logic [DATA_W-1:0] rs_val, rt_val, wr_dat, pc_plus4;
  logic [DATA_W-1:0] alu_b, add_b, alu_out, br_target;
  logic [DATA_W:0]   add_ext;
  logic [SH_W-1:0]   sh;
  logic              is_comp, br_taken, wr_en;

  assign rs_idx   = ir_q[RS_LSB +: REG_IDX_W];
  assign rt_idx   = ir_q[RT_LSB +: REG_IDX_W];
  assign opcode   = ir_q[OPCODE_LSB +: 6];
  assign funccode = ir_q[FUNC_LSB +: 6];
  assign pc_plus4 = pc_q + DATA_W'(4);

  mc_register_file #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regs (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rs_idx),
    .rd_addr_b (rt_idx),
    .rd_data_a (rs_val),
    .rd_data_b (rt_val),
    .wr_en     (wr_en),
    .wr_addr   (wr_idx),
    .wr_data   (wr_dat)
  );

  always_comb begin
    alu_b = rt_val;
    case (ALUsource)
      SRC_IMM:   alu_b = DATA_W'($signed(ir_q[IMM_LSB +: 16]));
      SRC_SHAMT: alu_b = DATA_W'(ir_q[SHAMT_LSB +: 5]);
      default:   alu_b = rt_val;
    endcase
  end

  // comp shares the adder: a + ~b + 1, so its carry-out is the same DATA_W-bit carry
  assign is_comp = (ALUop == ALU_COMP);
  assign add_b   = is_comp ? ~alu_b : alu_b;
  assign add_ext = {1'b0, rs_val} + {1'b0, add_b} + {{DATA_W{1'b0}}, is_comp};
  assign sh      = alu_b[SH_W-1:0];

  always_comb begin
    alu_out = '0;
    case (ALUop)
      ALU_ADD, ALU_COMP: alu_out = add_ext[DATA_W-1:0];
      ALU_AND:           alu_out = rs_val & alu_b;
      ALU_XOR:           alu_out = rs_val ^ alu_b;
      ALU_SLL:           alu_out = rs_val << sh;
      ALU_SRL:           alu_out = rs_val >> sh;
      ALU_SRA:           alu_out = $signed(rs_val) >>> sh;
      default:           alu_out = alu_b;
    endcase
  end

  // Conditions use carry_q before this instruction's own update lands
  always_comb begin
    br_taken = 1'b0;
    case (branch)
      BR_JUMP, BR_JR: br_taken = 1'b1;
      BR_NEG:         br_taken = rs_val[DATA_W-1];
      BR_ZERO:        br_taken = (rs_val == '0);
      BR_NZERO:       br_taken = (rs_val != '0);
      BR_CARRY:       br_taken = carry_q;
      BR_NCARRY:      br_taken = ~carry_q;
      default:        br_taken = 1'b0;
    endcase
    br_target = (branch == BR_JR) ? rs_val : DATA_W'({ir_q[PDA_LSB +: 26], 2'b00});
  end

  always_comb begin
    wr_idx = rt_idx;
    case (reg_dest)
      DEST_RS:   wr_idx = rs_idx;
      DEST_LINK: wr_idx = LINK_REG;
      default:   wr_idx = rt_idx;
    endcase
    wr_dat = result_q;
    case (mem_to_reg)
      M2R_MEM:  wr_dat = load_q;
      M2R_LINK: wr_dat = pc_plus4;
      default:  wr_dat = result_q;
    endcase
  end

  assign wr_en = (state_q == WB) && reg_write;

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    retire      = 1'b0;
    case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = EXEC;
      end
      EXEC: state_d = (mem_write || mem_to_reg == M2R_MEM) ? MEM : WB;
      MEM: begin
        mem_req = 1'b1;
        mem_we  = mem_write;
        if (mem_ack) state_d = WB;
      end
      WB: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
      load_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: if (instr_valid) ir_q <= instruction;
        EXEC: begin
          result_q <= alu_out;
          taken_q  <= br_taken;
          target_q <= br_target;
          if (ALUop == ALU_ADD || ALUop == ALU_COMP) carry_q <= add_ext[DATA_W];
        end
        MEM: if (mem_ack) load_q <= mem_rdata;
        WB: pc_q <= taken_q ? target_q : pc_plus4;
        default: ;
      endcase
    end
  end

  assign pc        = pc_q;
  assign result    = result_q;
  assign mem_addr  = result_q;
  assign mem_wdata = rt_val;

endmodule
